instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/ifq_pkg.sv | 18 +
 rtl/ifq_fifo.sv | 77 +++++++
 rtl/instr_fetch_queue.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ifq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DROP
   } ifq_state_e;

   localparam int unsigned IFQ_DEFAULT_DEPTH    = 4;
   localparam logic [31:0] IFQ_DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of fetched {instr, pc4} entries with synchronous clear.
module ifq_fifo
   import ifq_pkg::*;
#(
   parameter int unsigned DEPTH = IFQ_DEFAULT_DEPTH
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  ifq_entry_t               push_data_i,
   input  logic                     pop_i,
   output ifq_entry_t               head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   ifq_entry_t    mem_q [DEPTH];
   ifq_entry_t    mem_d [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      // Clear wins over any push/pop in the same cycle.
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch FSM with PC tracking feeding ifq_fifo.
// Define IFQ_PERF_COUNTERS_EN to build the saturating fetch/drop counters.
module instr_fetch_queue
   import ifq_pkg::*;
#(
   parameter int unsigned DEPTH    = IFQ_DEFAULT_DEPTH,
   parameter logic [31:0] RESET_PC = IFQ_DEFAULT_RESET_PC
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc4_o,
   input  logic        instr_ready_i,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] drop_cnt_o
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   ifq_state_e    state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;

   logic          fifo_push, fifo_pop, fifo_clear;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   ifq_entry_t    push_entry, head_entry;

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fetch_pc_d = fetch_pc_q;
      fifo_push  = 1'b0;
      fifo_clear = redirect_i;
      fifo_pop   = instr_ready_i && !fifo_empty && !redirect_i;
      push_entry = '{instr: mem_data_i, pc4: mem_addr_q + 32'd4};

      if (redirect_i) begin
         fetch_pc_d = redirect_pc_i;
      end

      case (state_q)
         ST_IDLE: begin
            // Occupancy before any same-cycle pop decides issue.
            if (!redirect_i && (fifo_count < CW'(DEPTH))) begin
               state_d    = ST_WAIT;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_pc_q;
            end
         end
         ST_WAIT: begin
            if (mem_ack_i) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               if (!redirect_i) begin
                  fifo_push  = !fifo_full;
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end else if (redirect_i) begin
               state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (mem_ack_i) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= RESET_PC;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   ifq_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (fifo_clear),
      .push_i      (fifo_push),
      .push_data_i (push_entry),
      .pop_i       (fifo_pop),
      .head_o      (head_entry),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign mem_req_o     = mem_req_q;
   assign mem_addr_o    = mem_addr_q;
   assign instr_valid_o = !fifo_empty;
   assign instr_o       = head_entry.instr;
   assign pc4_o         = head_entry.pc4;

`ifdef IFQ_PERF_COUNTERS_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;
   logic        drop_evt;

   always_comb begin
      drop_evt    = mem_ack_i && ((state_q == ST_DROP) ||
                                  ((state_q == ST_WAIT) && redirect_i));
      fetch_cnt_d = fetch_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      if (fifo_push && (fetch_cnt_q != '1)) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (drop_evt && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign drop_cnt_o  = drop_cnt_q;
`else
   assign fetch_cnt_o = '0;
   assign drop_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a transaction-level queue model.
module tb_instr_fetch_queue;

   localparam int unsigned TB_DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc4_o;
   logic        instr_ready_i;
   logic [31:0] fetch_cnt_o;
   logic [31:0] drop_cnt_o;

   instr_fetch_queue #(
      .DEPTH    (TB_DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ack_i     (mem_ack_i),
      .mem_data_i    (mem_data_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .pc4_o         (pc4_o),
      .instr_ready_i (instr_ready_i),
      .fetch_cnt_o   (fetch_cnt_o),
      .drop_cnt_o    (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } tb_ent_t;

   // Reference model: one outstanding fetch, a doomed flag, and a plain queue.
   tb_ent_t     mq[$];
   logic [31:0] m_pc;
   bit          m_out;
   bit          m_doomed;
   logic [31:0] m_out_addr;
   logic [31:0] m_fetch;
   logic [31:0] m_drop;

   int          checks = 0;
   int          errors = 0;
   bit          auto_mem = 0;
   int unsigned lat_max = 0;
   int unsigned lat_left = 0;
   bit          lat_armed = 0;
   bit          log_en = 0;
   logic [31:0] log_pc4[$];
   logic [31:0] log_ins[$];

   function automatic logic [31:0] memword(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef IFQ_PERF_COUNTERS_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc       = 32'h0000_0000;
      m_out      = 0;
      m_doomed   = 0;
      m_out_addr = 32'h0;
      m_fetch    = 32'h0;
      m_drop     = 32'h0;
   endtask

   task automatic model_step();
      logic [31:0] old_pc;
      bit          pop;
      bit          issue;
      old_pc = m_pc;
      pop    = instr_ready_i && (mq.size() != 0) && !redirect_i;
      issue  = !m_out && !redirect_i && (mq.size() < TB_DEPTH);
      if (pop) void'(mq.pop_front());
      if (m_out && mem_ack_i) begin
         if (m_doomed || redirect_i) begin
            if (m_drop != 32'hFFFF_FFFF) m_drop++;
         end else begin
            mq.push_back('{instr: mem_data_i, pc4: m_out_addr + 32'd4});
            m_pc = m_out_addr + 32'd4;
            if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
         end
         m_out = 0;
      end else if (m_out && redirect_i) begin
         m_doomed = 1;
      end
      if (redirect_i) begin
         mq.delete();
         m_pc = redirect_pc_i;
      end
      if (issue) begin
         m_out      = 1;
         m_out_addr = old_pc;
         m_doomed   = 0;
      end
   endtask

   task automatic compare();
      chk("mem_req", {31'd0, mem_req_o}, {31'd0, m_out});
      if (m_out) chk("mem_addr", mem_addr_o, m_out_addr);
      chk("instr_valid", {31'd0, instr_valid_o}, {31'd0, (mq.size() != 0)});
      if (mq.size() != 0) begin
         chk("instr", instr_o, mq[0].instr);
         chk("pc4", pc4_o, mq[0].pc4);
      end
      chk("fetch_cnt", fetch_cnt_o, exp_cnt(m_fetch));
      chk("drop_cnt", drop_cnt_o, exp_cnt(m_drop));
   endtask

   task automatic drive_mem();
      if (m_out) begin
         if (!lat_armed) begin
            lat_left  = $urandom_range(lat_max, 0);
            lat_armed = 1;
         end
         if (lat_left == 0) begin
            mem_ack_i  = 1'b1;
            mem_data_i = memword(m_out_addr);
            lat_armed  = 0;
         end else begin
            mem_ack_i  = 1'b0;
            mem_data_i = $urandom;
            lat_left--;
         end
      end else begin
         mem_ack_i  = 1'b0;
         mem_data_i = $urandom;
         lat_armed  = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      model_step();
      compare();
      if (log_en && instr_valid_o && instr_ready_i && !redirect_i) begin
         log_pc4.push_back(pc4_o);
         log_ins.push_back(instr_o);
      end
      if (auto_mem) drive_mem();
   endtask

   // Called just after a tick; pulses reset well before the next edge.
   task automatic pulse_reset();
      #1 rst_i = 1'b1;
      #1;
      chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("rst_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_fetch_cnt", fetch_cnt_o, 32'd0);
      chk("rst_drop_cnt", drop_cnt_o, 32'd0);
      model_reset();
      mem_ack_i  = 1'b0;
      redirect_i = 1'b0;
      lat_armed  = 0;
      #1 rst_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i         = 1'b1;
      mem_ack_i     = 1'b0;
      mem_data_i    = 32'h0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      instr_ready_i = 1'b1;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      chk("init_req", {31'd0, mem_req_o}, 32'd0);
      chk("init_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("init_fetch_cnt", fetch_cnt_o, 32'd0);
      chk("init_drop_cnt", drop_cnt_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // In-order fetch with single-cycle memory and ready held high.
      auto_mem = 1; lat_max = 0; log_en = 1;
      tick();
      chk("first_req", {31'd0, mem_req_o}, 32'd1);
      chk("first_addr", mem_addr_o, 32'h0);
      tick();
      chk("ack_to_valid", {31'd0, instr_valid_o}, 32'd1);
      chk("first_pc4", pc4_o, 32'h4);
      for (int n = 0; n < 40 && log_pc4.size() < 3; n++) tick();
      chk("seq_count", log_pc4.size(), 32'd3);
      if (log_pc4.size() >= 3) begin
         chk("seq_pc4_0", log_pc4[0], 32'h4);
         chk("seq_pc4_1", log_pc4[1], 32'h8);
         chk("seq_pc4_2", log_pc4[2], 32'hC);
         chk("seq_ins_0", log_ins[0], memword(32'h0));
         chk("seq_ins_2", log_ins[2], memword(32'h8));
      end
      log_en = 0;

      // Backpressure: queue fills to DEPTH and requests stop.
      pulse_reset();
      instr_ready_i = 1'b0;
      repeat (20) tick();
      chk("full_no_req", {31'd0, mem_req_o}, 32'd0);
      chk("full_valid", {31'd0, instr_valid_o}, 32'd1);
      chk("full_head_pc4", pc4_o, 32'h4);
      instr_ready_i = 1'b1;
      tick();
      instr_ready_i = 1'b0;
      chk("pop_no_req_yet", {31'd0, mem_req_o}, 32'd0);
      chk("pop_next_head", pc4_o, 32'h8);
      tick();
      chk("refill_req", {31'd0, mem_req_o}, 32'd1);
      chk("refill_addr", mem_addr_o, 32'h10);
      repeat (4) tick();

      // Redirect while a request to 0x10 is outstanding; late ack is dropped.
      pulse_reset();
      instr_ready_i = 1'b1;
      for (int n = 0; n < 50 && !(m_out && m_out_addr == 32'h10); n++) tick();
      chk("reach_req_10", {31'd0, (m_out && m_out_addr == 32'h10)}, 32'd1);
      auto_mem = 0; mem_ack_i = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'h100;
      tick();
      redirect_i = 1'b0;
      chk("drop_req_held", {31'd0, mem_req_o}, 32'd1);
      chk("drop_addr_held", mem_addr_o, 32'h10);
      chk("redir_flush", {31'd0, instr_valid_o}, 32'd0);
      tick();
      tick();
      mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
      tick();
      mem_ack_i = 1'b0;
      chk("drop_cnt_one", drop_cnt_o, exp_cnt(32'd1));
      chk("drop_empty", {31'd0, instr_valid_o}, 32'd0);
      chk("drop_idle", {31'd0, mem_req_o}, 32'd0);
      tick();
      chk("redir_req", {31'd0, mem_req_o}, 32'd1);
      chk("redir_addr", mem_addr_o, 32'h100);

      // Redirect coincident with ack.
      mem_ack_i = 1'b1; mem_data_i = 32'hCAFE_F00D;
      redirect_i = 1'b1; redirect_pc_i = 32'h200;
      tick();
      mem_ack_i = 1'b0; redirect_i = 1'b0;
      chk("coinc_not_enq", {31'd0, instr_valid_o}, 32'd0);
      chk("coinc_drop_cnt", drop_cnt_o, exp_cnt(32'd2));
      tick();
      chk("coinc_req", {31'd0, mem_req_o}, 32'd1);
      chk("coinc_addr", mem_addr_o, 32'h200);

      // Redirect in IDLE, then fetch at the top of the address space.
      instr_ready_i = 1'b0;
      mem_ack_i = 1'b1; mem_data_i = memword(32'h200);
      tick();
      mem_ack_i = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      redirect_i = 1'b0;
      chk("idle_redir_no_req", {31'd0, mem_req_o}, 32'd0);
      tick();
      chk("wrap_req_addr", mem_addr_o, 32'hFFFF_FFFC);
      mem_ack_i = 1'b1; mem_data_i = memword(32'hFFFF_FFFC);
      tick();
      mem_ack_i = 1'b0;
      chk("wrap_pc4", pc4_o, 32'h0);
      tick();
      chk("wrap_next_addr", mem_addr_o, 32'h0);

      // Reset in the middle of a fetch with two entries queued.
      pulse_reset();
      auto_mem = 1; lat_max = 2; instr_ready_i = 1'b0;
      for (int n = 0; n < 60 && !(mq.size() == 2 && m_out); n++) tick();
      chk("reach_two_queued", {31'd0, (mq.size() == 2 && m_out)}, 32'd1);
      chk("pre_rst_valid", {31'd0, instr_valid_o}, 32'd1);
      pulse_reset();
      auto_mem = 0;
      mem_ack_i = 1'b1; mem_data_i = 32'h0BAD_0BAD;
      tick();
      mem_ack_i = 1'b0;
      chk("post_rst_req", {31'd0, mem_req_o}, 32'd1);
      chk("post_rst_addr", mem_addr_o, 32'h0);
      chk("late_ack_ignored", {31'd0, instr_valid_o}, 32'd0);

      // Ten fetches and the performance counter.
      pulse_reset();
      auto_mem = 1; lat_max = 1; instr_ready_i = 1'b1;
      for (int n = 0; n < 200 && m_fetch < 32'd10; n++) tick();
      chk("ten_fetch_cnt", fetch_cnt_o, exp_cnt(32'd10));

      // Random traffic.
      lat_max = 3;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (i == 1500) pulse_reset();
         instr_ready_i = ($urandom_range(3, 0) != 0);
         redirect_i    = ($urandom_range(11, 0) == 0);
         if ($urandom_range(3, 0) == 0)
            redirect_pc_i = 32'hFFFF_FFF0 + {$urandom_range(3, 0), 2'b00};
         else
            redirect_pc_i = {$urandom} & 32'hFFFF_FFFC;
      end
      redirect_i = 1'b0;
      auto_mem   = 0;
      mem_ack_i  = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
